scan_master: RTL and testbench



---
 rtl/scan_master.sv | 162 ++++++++++++++++
 tb/tb_scan_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_master : host-side initiator for the pattern-buffer serial scan     |
// |   port; one parallel request becomes one framed serial shift.            |
// |   Build option: define SCAN_LSB_FIRST_EN for LSB-first shift/capture.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scan_master #(
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            addr,
  input  logic [FRAME_BITS-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rdata,
  output logic                  sclk,
  output logic                  sin,
  output logic                  ssel,
  output logic [2:0]            saddr,
  input  logic                  sout
);

  localparam int DIV_W = $clog2(SCLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_BITS);
`ifdef SCAN_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [DIV_W-1:0]      div_cnt, div_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_nx;
  logic [FRAME_BITS-1:0] tx_sr, tx_nx;
  logic [FRAME_BITS-1:0] cap_sr, cap_nx;
  logic [FRAME_BITS-1:0] rdata_nx;
  logic [FRAME_BITS-1:0] cap_shifted;
  logic                  busy_nx, done_nx, sclk_nx, sin_nx, ssel_nx;
  logic [2:0]            saddr_nx;
  logic                  div_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      cap_sr  <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      sin     <= 1'b0;
      ssel    <= 1'b0;
      saddr   <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      tx_sr   <= tx_nx;
      cap_sr  <= cap_nx;
      rdata   <= rdata_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      sclk    <= sclk_nx;
      sin     <= sin_nx;
      ssel    <= ssel_nx;
      saddr   <= saddr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    div_nx      = div_cnt;
    bit_nx      = bit_cnt;
    tx_nx       = tx_sr;
    cap_nx      = cap_sr;
    rdata_nx    = rdata;
    busy_nx     = busy;
    done_nx     = 1'b0;
    sclk_nx     = sclk;
    sin_nx      = sin;
    ssel_nx     = ssel;
    saddr_nx    = saddr;
    div_end     = (div_cnt == DIV_W'(1));
    cap_shifted = LSB_FIRST ? {sout, cap_sr[FRAME_BITS-1:1]}
                            : {cap_sr[FRAME_BITS-2:0], sout};

    if (state != IDLE && !div_end) begin
      div_nx = div_cnt - DIV_W'(1);
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SETUP;
          div_nx   = DIV_LOAD;
          bit_nx   = BIT_LOAD;
          tx_nx    = wdata;
          cap_nx   = '0;
          busy_nx  = 1'b1;
          ssel_nx  = 1'b1;
          saddr_nx = addr;
          sclk_nx  = 1'b0;
          sin_nx   = LSB_FIRST ? wdata[0] : wdata[FRAME_BITS-1];
        end
      end
      SETUP: begin
        if (div_end) begin
          state_nx = SHIFT;
          div_nx   = DIV_LOAD;
          sclk_nx  = 1'b1;
          cap_nx   = cap_shifted;
        end
      end
      SHIFT: begin
        if (div_end) begin
          div_nx = DIV_LOAD;
          if (sclk) begin
            // Falling edge: advance sin unless this was the final bit.
            sclk_nx = 1'b0;
            bit_nx  = bit_cnt - BIT_W'(1);
            if (bit_cnt != BIT_W'(1)) begin
              tx_nx  = LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);
              sin_nx = LSB_FIRST ? tx_sr[1] : tx_sr[FRAME_BITS-2];
            end
          end else if (bit_cnt == '0) begin
            state_nx = HOLD;
            ssel_nx  = 1'b0;
          end else begin
            sclk_nx = 1'b1;
            cap_nx  = cap_shifted;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          rdata_nx = cap_sr;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_master.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_scan_master : self-checking bench for scan_master.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_scan_master;
  localparam int FB   = 8;
  localparam int DIV0 = 4;
  localparam int LAT0 = 1 + DIV0 * (2 + 2 * FB);
  localparam int LAT1 = 1 + 1 * (2 + 2 * FB);

  typedef struct {
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] chain;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, sout = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk, sin, ssel;
  logic [7:0] rdata;
  logic [2:0] saddr;

  logic       start1 = 1'b0;
  logic       sout1 = 1'b1;
  logic [2:0] addr1 = 3'd6;
  logic [7:0] wdata1 = 8'h3C;
  logic       busy1, done1, sclk1, sin1, ssel1;
  logic [7:0] rdata1;
  logic [2:0] saddr1;

  scan_master #(.SCLK_DIV(DIV0), .FRAME_BITS(FB)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .sin(sin),
    .ssel(ssel), .saddr(saddr), .sout(sout)
  );

  scan_master #(.SCLK_DIV(1), .FRAME_BITS(FB)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .rdata(rdata1), .sclk(sclk1), .sin(sin1),
    .ssel(ssel1), .saddr(saddr1), .sout(sout1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit i of the serial frame as it should appear on sin.
  function automatic logic exp_sin_bit(input logic [7:0] w, input int i);
`ifdef SCAN_LSB_FIRST_EN
    return w[3'(i)];
`else
    return w[3'(7 - i)];
`endif
  endfunction

  // Chain value streams out MSB first; place each received bit by capture order.
  function automatic logic [7:0] exp_rd(input logic [7:0] chain);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SCAN_LSB_FIRST_EN
      r[3'(i)] = chain[3'(7 - i)];
`else
      r[3'(7 - i)] = chain[3'(7 - i)];
`endif
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input int extra_a, input int extra_b,
                         input int abort_at);
    int         cyc = 0, rises = 0, falls = 0;
    logic       prev_sclk = 1'b0;
    bit         seen_done = 1'b0, addr_ok = 1'b1;
    logic [7:0] sin_bits = '0, exp_bits = '0;
    for (int i = 0; i < 8; i++) exp_bits[3'(7 - i)] = exp_sin_bit(v.wdata, i);
    sb.push_back(v.exp_rdata);
    sout  = v.chain[7];
    addr  = v.addr;
    wdata = v.wdata;
    start = 1'b1;
    while (!seen_done && cyc < LAT0 + 20) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == extra_a) || (cyc == extra_b);
      if (abort_at > 0 && cyc == abort_at) reset = 1'b1;
      if (abort_at > 0 && cyc == abort_at + 1) begin
        reset = 1'b0;
        check("abort_ssel", int'(ssel), 0);
        check("abort_sclk", int'(sclk), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_rdata", int'(rdata), 0);
        void'(sb.pop_back());
        return;
      end
      if (cyc == 1) begin
        check("accept_busy", int'(busy), 1);
        check("accept_ssel", int'(ssel), 1);
        check("accept_sin", int'(sin), int'(exp_bits[7]));
      end
      if (ssel && saddr !== v.addr) addr_ok = 1'b0;
      if (sclk && !prev_sclk) begin
        if (rises < 8) sin_bits[3'(7 - rises)] = sin;
        rises++;
      end
      if (!sclk && prev_sclk) begin
        falls++;
        if (falls < 8) sout = v.chain[3'(7 - falls)];
      end
      prev_sclk = sclk;
      if (done) seen_done = 1'b1;
    end
    if (!seen_done) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
      return;
    end
    check("latency", cyc, LAT0);
    check("sclk_rises", rises, 8);
    check("sin_bits", int'(sin_bits), int'(exp_bits));
    check("saddr_held", int'(addr_ok), 1);
    check("done_busy", int'(busy), 0);
    check("rdata", int'(rdata), int'(sb.pop_front()));
    @(posedge clk); #1;
    check("done_pulse", int'(done), 0);
  endtask

  initial begin
    int         bad, last_done, n_done;
    vecs[0] = '{addr: 3'd5, wdata: 8'hA5, chain: 8'h3C, exp_rdata: exp_rd(8'h3C)};
    vecs[1] = '{addr: 3'd2, wdata: 8'h01, chain: 8'h80, exp_rdata: exp_rd(8'h80)};
    vecs[2] = '{addr: 3'd7, wdata: 8'hFF, chain: 8'h00, exp_rdata: exp_rd(8'h00)};
    vecs[3] = '{addr: 3'd0, wdata: 8'h00, chain: 8'hFF, exp_rdata: exp_rd(8'hFF)};
    vecs[4] = '{addr: 3'd3, wdata: 8'h5A, chain: 8'hC3, exp_rdata: exp_rd(8'hC3)};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_sclk", int'(sclk), 0);
    check("rst_sin", int'(sin), 0);
    check("rst_ssel", int'(ssel), 0);
    check("rst_saddr", int'(saddr), 0);

    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sclk || sin || ssel || busy || done || rdata != 8'h00) bad++;
    end
    check("idle_quiet", bad, 0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], 0, 0, 0);

    // Starts during an active frame are dropped, not queued.
    run_txn(vecs[0], 10, 40, 0);
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy || ssel || done) bad++;
    end
    check("no_queued_start", bad, 0);

    run_txn(vecs[2], 0, 0, 30);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done || busy || ssel || sclk) bad++;
    end
    check("abort_quiet", bad, 0);
    run_txn(vecs[0], 0, 0, 0);

    // Back-to-back frames with start held high on the fast instance.
    start1    = 1'b1;
    last_done = 0;
    n_done    = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == last_done + 1 && n_done > 0) check("b2b_reaccept", int'(busy1), 1);
      if (done1) begin
        n_done++;
        check("b2b_period", c - last_done, LAT1);
        check("b2b_rdata", int'(rdata1), int'(exp_rd(8'hFF)));
        last_done = c;
      end
    end
    check("b2b_count", n_done, 5);
    start1 = 1'b0;
    repeat (30) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
